writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Write-side driver of register_file: owns write_en/addressC/writeBack. Arbitrates
//  ALU and load-unit results onto the single register-file write port, sign/zero-
//  extends load data, drops writes to x0, and keeps a per-register busy scoreboard
//  (set at issue, cleared at writeback) that decode reads for RAW stalls.
// PARAMETERS
//  BUS_DATA_WIDTH  64  register / result width in bits
// PORTS
//  clk          in   1     single clock; all state on posedge
//  reset        in   1     asynchronous, active-high
//  alu_valid    in   1     ALU result pending
//  alu_ready    out  1     ALU result accepted this cycle
//  alu_rd       in   5     ALU destination register
//  alu_result   in   W     ALU result, W = BUS_DATA_WIDTH
//  ld_valid     in   1     load result pending
//  ld_ready     out  1     load result accepted this cycle
//  ld_rd        in   5     load destination register
//  ld_data      in   W     raw load data, right-justified
//  ld_size      in   2     0=byte 1=half 2=word 3=dword
//  ld_unsigned  in   1     1=zero-extend, 0=sign-extend
//  issue_en     in   1     decode issued an instruction with a destination
//  issue_rd     in   5     its destination register
//  busy         out  32    busy[i]=1: write to x(i) outstanding; busy[0] always 0
//  write_en     out  1     register_file write enable
//  addressC     out  5     register_file write address
//  writeBack    out  W     register_file write data
// BEHAVIOUR
//  Reset: write_en=0, addressC=0, writeBack=0, busy=0, rr_last=1 (ALU first).
//  Handshake: source transfers on posedge when valid&&ready. ready is
//   combinational, never asserted without the matching valid; at most one of
//   alu_ready/ld_ready high per cycle. No backpressure from register_file.
//  Arbitration: only one valid -> it wins. Both valid -> round-robin on rr_last
//   (0=ALU last, 1=load last); winner is the other source; rr_last updates only on
//   a transfer. Source not granted must hold valid and payload stable.
//  Load extension (combinational, before output register): size 0 -> bits[7:0],
//   1 -> [15:0], 2 -> [31:0], 3 -> all W bits; upper bits = 0 if ld_unsigned else
//   copy of top kept bit. ALU result passes unchanged.
//  Output pipeline: transfer in cycle N -> write_en=1, addressC=rd, writeBack=data
//   during cycle N+1 for exactly one cycle; latency 1. No transfer -> write_en=0,
//   addressC/writeBack hold previous values.
//  x0: rd==0 still transferred (ready asserted, rr_last updates) but write_en stays
//   0 next cycle; issue_rd==0 ignored; busy[0] hard 0.
//  Scoreboard, per rd!=0 each posedge: set if issue_en&&issue_rd==rd; else clear if
//   transfer with that rd; else hold. Set wins over clear for the same register
//   (newer producer). Clear happens at transfer edge (cycle N), so busy drops as
//   write_en rises; decode forwarding covers the N+1 gap.
//  Reset mid-operation: async reset clears everything at once; transfer in that
//   cycle is lost; no write_en glitch after reset deasserts.
// TESTING
//  ALU only: alu_rd=5, result=0x1234 -> alu_ready same cycle; next cycle write_en=1,
//   addressC=5, writeBack=0x1234; following cycle write_en=0.
//  Loads: data=0x80, size0 signed -> 0xFFFF_FFFF_FFFF_FF80; unsigned -> 0x80;
//   data=0x8000_0000 size2 signed -> 0xFFFF_FFFF_8000_0000.
//  Both valid 4 cycles from reset: grants ALU,load,ALU,load; one write_en per cycle.
//  issue rd=7 -> busy[7]=1; ALU rd=7 transfer -> 0; same-cycle issue+writeback rd=7
//   -> busy[7] stays 1.
//  rd=0 ALU result 0xDEAD -> alu_ready=1, write_en never 1, busy[0]=0.
//  Assert reset while busy=0x0000_00F0 and write_en=1 -> busy=0, write_en=0 at once.

Source files
------------

// File: rtl/writeback_unit.sv
// Register-file write port driver: round-robin arbitration of ALU and load results,
// load sign/zero extension, one-cycle registered write, and per-register busy scoreboard.
module writeback_unit #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [4:0]                alu_rd,
    input  logic [BUS_DATA_WIDTH-1:0] alu_result,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [4:0]                ld_rd,
    input  logic [BUS_DATA_WIDTH-1:0] ld_data,
    input  logic [1:0]                ld_size,
    input  logic                      ld_unsigned,
    input  logic                      issue_en,
    input  logic [4:0]                issue_rd,
    output logic [31:0]               busy,
    output logic                      write_en,
    output logic [4:0]                addressC,
    output logic [BUS_DATA_WIDTH-1:0] writeBack
);
    localparam int W = BUS_DATA_WIDTH;

    logic         r_rr_last;   // 1: load was served last, so ALU has priority
    logic         r_write_en;
    logic [4:0]   r_addr;
    logic [W-1:0] r_data;
    logic [31:1]  r_busy;

    logic         w_grant_alu;
    logic         w_grant_ld;
    logic         w_xfer;
    logic [4:0]   w_rd;
    logic [W-1:0] w_data;
    logic [W-1:0] w_ld_ext;
    logic         w_fill;

    assign w_grant_alu = alu_valid && (!ld_valid || r_rr_last);
    assign w_grant_ld  = ld_valid && !w_grant_alu;
    assign w_xfer      = w_grant_alu || w_grant_ld;
    assign alu_ready   = w_grant_alu;
    assign ld_ready    = w_grant_ld;

    always_comb begin
        w_fill   = 1'b0;
        w_ld_ext = ld_data;
        case (ld_size)
            2'd0: begin
                w_fill   = !ld_unsigned && ld_data[7];
                w_ld_ext = {{(W-8){w_fill}}, ld_data[7:0]};
            end
            2'd1: begin
                w_fill   = !ld_unsigned && ld_data[15];
                w_ld_ext = {{(W-16){w_fill}}, ld_data[15:0]};
            end
            2'd2: begin
                w_fill   = !ld_unsigned && ld_data[31];
                w_ld_ext = {{(W-32){w_fill}}, ld_data[31:0]};
            end
            default: w_ld_ext = ld_data;
        endcase
    end

    assign w_rd   = w_grant_alu ? alu_rd : ld_rd;
    assign w_data = w_grant_alu ? alu_result : w_ld_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_last  <= 1'b1;
            r_write_en <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            // x0 results still consume a grant but never reach the register file
            r_write_en <= w_xfer && (w_rd != 5'd0);
            if (w_xfer) begin
                r_rr_last <= w_grant_ld;
                r_addr    <= w_rd;
                r_data    <= w_data;
            end
        end
    end

    // A new issue to the same register outranks the older producer's writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (issue_en && issue_rd == 5'(i))
                    r_busy[i] <= 1'b1;
                else if (w_xfer && w_rd == 5'(i))
                    r_busy[i] <= 1'b0;
            end
        end
    end

    assign busy      = {r_busy, 1'b0};
    assign write_en  = r_write_en;
    assign addressC  = r_addr;
    assign writeBack = r_data;
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed cases then randomized traffic.
module tb_writeback_unit;
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        int          cyc;
    } wb_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        alu_valid = 0, ld_valid = 0, ld_unsigned = 0, issue_en = 0;
    logic [4:0]  alu_rd = 0, ld_rd = 0, issue_rd = 0;
    logic [63:0] alu_result = 0, ld_data = 0;
    logic [1:0]  ld_size = 0;
    logic        alu_ready, ld_ready, write_en;
    logic [31:0] busy;
    logic [4:0]  addressC;
    logic [63:0] writeBack;

    int   n_checks = 0, n_fail = 0, cyc = 0;
    wb_t  q[$];
    logic [31:0] m_busy;
    logic m_last_alu;
    logic lg_alu, lg_ld;

    writeback_unit #(.BUS_DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .issue_en(issue_en), .issue_rd(issue_rd), .busy(busy),
        .write_en(write_en), .addressC(addressC), .writeBack(writeBack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [1:0] sz, input logic uns);
        int nbits;
        logic [63:0] mask, v;
        nbits = 8 << sz;
        mask = (sz == 2'd3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
        v = d & mask;
        if (!uns && d[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    // Monitor: every cycle write_en must match whether an accepted result is due
    always @(negedge clk) begin
        wb_t e;
        logic due;
        if (!reset) begin
            due = (q.size() > 0) && (q[0].cyc < cyc);
            chk("write_en", {63'd0, write_en}, {63'd0, due});
            if (due && write_en) begin
                e = q.pop_front();
                chk("addressC", {59'd0, addressC}, {59'd0, e.rd});
                chk("writeBack", writeBack, e.data);
            end
        end
    end

    // One cycle: check grants/busy against the model, record accepted result
    task automatic step();
        logic [4:0]  rd;
        logic [63:0] d;
        @(negedge clk);
        lg_alu = alu_valid && (!ld_valid || !m_last_alu);
        lg_ld  = ld_valid && !lg_alu;
        chk("alu_ready", {63'd0, alu_ready}, {63'd0, lg_alu});
        chk("ld_ready", {63'd0, ld_ready}, {63'd0, lg_ld});
        chk("busy", {32'd0, busy}, {32'd0, m_busy});
        if (lg_alu || lg_ld) begin
            rd = lg_alu ? alu_rd : ld_rd;
            d  = lg_alu ? alu_result : ext_model(ld_data, ld_size, ld_unsigned);
            m_last_alu = lg_alu;
            if (rd != 0) begin
                q.push_back('{rd, d, cyc});
                m_busy[rd] = 1'b0;
            end
        end
        if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; ld_valid = 0; issue_en = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        q.delete();
        m_busy = '0;
        m_last_alu = 1'b0;
        lg_alu = 0; lg_ld = 0;
        #1;
        chk("rst_write_en", {63'd0, write_en}, 64'd0);
        chk("rst_busy", {32'd0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        chk("post_rst_write_en", {63'd0, write_en}, 64'd0);
    endtask

    initial begin
        m_busy = '0;
        m_last_alu = 1'b0;
        #1;
        chk("reset_addressC", {59'd0, addressC}, 64'd0);
        chk("reset_writeBack", writeBack, 64'd0);
        do_reset();

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_result = 64'h1234;
        step();
        alu_valid = 0;
        chk("alu_we", {63'd0, write_en}, 64'd1);
        chk("alu_addr", {59'd0, addressC}, 64'd5);
        chk("alu_data", writeBack, 64'h1234);
        step();
        chk("alu_we_drop", {63'd0, write_en}, 64'd0);

        // Load extension
        ld_valid = 1; ld_rd = 3; ld_data = 64'h80; ld_size = 0; ld_unsigned = 0;
        step();
        chk("lb_signed", writeBack, 64'hFFFF_FFFF_FFFF_FF80);
        ld_unsigned = 1;
        step();
        chk("lbu", writeBack, 64'h80);
        ld_data = 64'h8000_0000; ld_size = 2; ld_unsigned = 0;
        step();
        chk("lw_signed", writeBack, 64'hFFFF_FFFF_8000_0000);
        ld_data = 64'hABCD_8001; ld_size = 1;
        step();
        chk("lh_signed", writeBack, 64'hFFFF_FFFF_FFFF_8001);
        ld_valid = 0;
        step();

        // Round-robin from reset
        do_reset();
        alu_valid = 1; alu_rd = 1; alu_result = 64'hA0;
        ld_valid = 1; ld_rd = 2; ld_data = 64'h11; ld_size = 3; ld_unsigned = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_seq", {63'd0, lg_alu}, {63'd0, (k % 2) == 0});
            if (lg_alu) alu_result = alu_result + 1;
            else ld_data = ld_data + 1;
        end
        idle_inputs();
        repeat (2) step();

        // Scoreboard
        issue_en = 1; issue_rd = 7;
        step();
        issue_en = 0;
        chk("busy7_set", {63'd0, busy[7]}, 64'd1);
        alu_valid = 1; alu_rd = 7; alu_result = 64'h77;
        step();
        alu_valid = 0;
        chk("busy7_clr", {63'd0, busy[7]}, 64'd0);
        issue_en = 1; issue_rd = 7; alu_valid = 1; alu_rd = 7; alu_result = 64'h78;
        step();
        idle_inputs();
        chk("busy7_set_wins", {63'd0, busy[7]}, 64'd1);
        step();

        // x0 destination
        alu_valid = 1; alu_rd = 0; alu_result = 64'hDEAD;
        issue_en = 1; issue_rd = 0;
        step();
        idle_inputs();
        chk("x0_ready", {63'd0, lg_alu}, 64'd1);
        chk("x0_busy0", {63'd0, busy[0]}, 64'd0);
        step();

        // Reset mid-operation
        do_reset();
        for (int r = 4; r < 8; r++) begin
            issue_en = 1; issue_rd = 5'(r);
            if (r == 7) begin alu_valid = 1; alu_rd = 9; alu_result = 64'h99; end
            step();
        end
        idle_inputs();
        chk("pre_rst_busy", {32'd0, busy}, 64'h0000_00F0);
        chk("pre_rst_we", {63'd0, write_en}, 64'd1);
        #1;
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (!(alu_valid && !lg_alu)) begin
                alu_valid  = ($urandom_range(0, 2) != 0);
                alu_rd     = 5'($urandom);
                alu_result = {$urandom, $urandom};
            end
            if (!(ld_valid && !lg_ld)) begin
                ld_valid    = ($urandom_range(0, 2) != 0);
                ld_rd       = 5'($urandom);
                ld_data     = {$urandom, $urandom};
                ld_size     = 2'($urandom);
                ld_unsigned = 1'($urandom);
            end
            issue_en = 1'($urandom);
            issue_rd = 5'($urandom);
            step();
        end
        idle_inputs();
        repeat (3) step();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
